// File: rtl/trace_line_checker_if.sv
// rtl/trace_line_checker_if.sv - byte-serial trace character stream
//
// Purpose: carries one ASCII trace character per clock under a valid qualifier.
// Signals:
//   char        8-bit ASCII character
//   char_valid  char is consumed on the rising edge only when 1
// Modports: master drives the stream (trace source), slave consumes it (checker).
interface trace_line_checker_if;
  logic [7:0] char;
  logic       char_valid;

  modport master (output char, char_valid);
  modport slave  (input  char, char_valid);
endinterface

// File: rtl/trace_line_checker.sv
// rtl/trace_line_checker.sv - parametrised CPU trace line syntax and semantic checker
//
// Purpose: parses "^T@P: $R <= D#" (register) and "^T@P: *A <= D#" (memory) lines
// from a byte stream, extracts the numeric fields and checks PC range, PC
// alignment, register range and address alignment.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   in_if        slave side of the character stream (char, char_valid)
//   format_type  1-cycle pulse on completion: 01 register line, 10 memory line
//   error_code   valid with the pulse: 0 ok, 1 PC range, 2 PC align, 3 reg range, 4 addr align
//   time_out     time field of the last completed line
//   pc_out       PC of the last completed line
//   target_out   register number or memory address of the last completed line
//   data_out     data field of the last completed line
//   good_cnt     number of completed lines with error_code 0 (wraps)
module trace_line_checker #(
  parameter int TIME_DIGITS = 4,
  parameter int TIME_W      = 14,
  parameter int HEX_DIGITS  = 8,
  parameter int REG_DIGITS  = 4,
  parameter int REG_COUNT   = 32,
  parameter logic [4*HEX_DIGITS-1:0] PC_MIN = 'h0000_3000,
  parameter logic [4*HEX_DIGITS-1:0] PC_MAX = 'h0000_6ffc,
  parameter int CNT_W       = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  trace_line_checker_if.slave       in_if,
  output logic [1:0]                format_type,
  output logic [2:0]                error_code,
  output logic [TIME_W-1:0]         time_out,
  output logic [4*HEX_DIGITS-1:0]   pc_out,
  output logic [4*HEX_DIGITS-1:0]   target_out,
  output logic [4*HEX_DIGITS-1:0]   data_out,
  output logic [CNT_W-1:0]          good_cnt
);
  localparam int W      = 4 * HEX_DIGITS;
  localparam int MAX_D  = (TIME_DIGITS > HEX_DIGITS) ?
                          ((TIME_DIGITS > REG_DIGITS) ? TIME_DIGITS : REG_DIGITS) :
                          ((HEX_DIGITS  > REG_DIGITS) ? HEX_DIGITS  : REG_DIGITS);
  localparam int CW     = $clog2(MAX_D + 1) + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_TIME, S_PC, S_SEL, S_REG, S_ADDR, S_PRE, S_EQ, S_DATA
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [TIME_W-1:0]  time_acc;
  logic [W-1:0]       pc_acc;
  logic [W-1:0]       tgt_acc;
  logic [W-1:0]       data_acc;
  logic               kind_mem;

  logic [7:0]         c;
  logic               is_dec;
  logic               is_hex;
  logic [3:0]         nib;
  logic [7:0]         nib_wide;
  logic [TIME_W-1:0]  time_next;
  logic [W-1:0]       reg_next;
  logic [2:0]         err;

  always_comb begin
    c        = in_if.char;
    is_dec   = (c >= "0") && (c <= "9");
    is_hex   = is_dec || ((c >= "a") && (c <= "f"));
    nib_wide = is_dec ? (c - 8'h30) : (c - 8'h57);
    nib      = nib_wide[3:0];
    time_next = time_acc * TIME_W'(10) + TIME_W'(nib);
    reg_next  = tgt_acc * W'(10) + W'(nib);
  end

  // Single highest-priority semantic error of the line being completed.
  always_comb begin
    err = 3'd0;
    if ((pc_acc < PC_MIN) || (pc_acc > PC_MAX))           err = 3'd1;
    else if (pc_acc[1:0] != 2'b00)                        err = 3'd2;
    else if (!kind_mem && (tgt_acc >= W'(REG_COUNT)))     err = 3'd3;
    else if (kind_mem && (tgt_acc[1:0] != 2'b00))         err = 3'd4;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      time_acc    <= '0;
      pc_acc      <= '0;
      tgt_acc     <= '0;
      data_acc    <= '0;
      kind_mem    <= 1'b0;
      format_type <= 2'b00;
      error_code  <= 3'd0;
      time_out    <= '0;
      pc_out      <= '0;
      target_out  <= '0;
      data_out    <= '0;
      good_cnt    <= '0;
    end else begin
      // Result outputs are single-cycle pulses regardless of char_valid.
      format_type <= 2'b00;
      error_code  <= 3'd0;
      if (in_if.char_valid) begin
        if (c == "^") begin
          // Resync: a line start is honoured from any state.
          state    <= S_TIME;
          cnt      <= '0;
          time_acc <= '0;
          pc_acc   <= '0;
          tgt_acc  <= '0;
          data_acc <= '0;
        end else begin
          // Every branch not explicitly accepting the character falls back to IDLE.
          state <= S_IDLE;
          cnt   <= '0;
          case (state)
            S_TIME: begin
              if (is_dec && cnt < CW'(TIME_DIGITS)) begin
                state    <= S_TIME;
                time_acc <= time_next;
                cnt      <= cnt + 1'b1;
              end else if (c == "@" && cnt != '0) begin
                state <= S_PC;
              end
            end
            S_PC: begin
              if (is_hex && cnt < CW'(HEX_DIGITS)) begin
                state  <= S_PC;
                pc_acc <= {pc_acc[W-5:0], nib};
                cnt    <= cnt + 1'b1;
              end else if (c == ":" && cnt == CW'(HEX_DIGITS)) begin
                state <= S_SEL;
              end
            end
            S_SEL: begin
              if (c == " ") begin
                state <= S_SEL;
              end else if (c == "$") begin
                state    <= S_REG;
                kind_mem <= 1'b0;
              end else if (c == "*") begin
                state    <= S_ADDR;
                kind_mem <= 1'b1;
              end
            end
            S_REG: begin
              if (is_dec && cnt < CW'(REG_DIGITS)) begin
                state   <= S_REG;
                tgt_acc <= reg_next;
                cnt     <= cnt + 1'b1;
              end else if (c == " " && cnt != '0) begin
                state <= S_PRE;
              end else if (c == "<" && cnt != '0) begin
                state <= S_EQ;
              end
            end
            S_ADDR: begin
              if (is_hex && cnt < CW'(HEX_DIGITS)) begin
                state   <= S_ADDR;
                tgt_acc <= {tgt_acc[W-5:0], nib};
                cnt     <= cnt + 1'b1;
              end else if (c == " " && cnt == CW'(HEX_DIGITS)) begin
                state <= S_PRE;
              end else if (c == "<" && cnt == CW'(HEX_DIGITS)) begin
                state <= S_EQ;
              end
            end
            S_PRE: begin
              if (c == " ")      state <= S_PRE;
              else if (c == "<") state <= S_EQ;
            end
            S_EQ: begin
              if (c == "=") state <= S_DATA;
            end
            S_DATA: begin
              // Leading spaces only: cnt==0 means no data digit seen yet.
              if (c == " " && cnt == '0) begin
                state <= S_DATA;
              end else if (is_hex && cnt < CW'(HEX_DIGITS)) begin
                state    <= S_DATA;
                data_acc <= {data_acc[W-5:0], nib};
                cnt      <= cnt + 1'b1;
              end else if (c == "#" && cnt == CW'(HEX_DIGITS)) begin
                format_type <= kind_mem ? 2'b10 : 2'b01;
                error_code  <= err;
                time_out    <= time_acc;
                pc_out      <= pc_acc;
                target_out  <= tgt_acc;
                data_out    <= data_acc;
                if (err == 3'd0) good_cnt <= good_cnt + 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_trace_line_checker.sv
// tb/tb_trace_line_checker.sv - directed self-checking bench for trace_line_checker
module tb_trace_line_checker;
  logic        clk;
  logic        reset;
  logic [1:0]  format_type;
  logic [2:0]  error_code;
  logic [13:0] time_out;
  logic [31:0] pc_out;
  logic [31:0] target_out;
  logic [31:0] data_out;
  logic [15:0] good_cnt;

  int total;
  int bad;
  int pulses;
  logic [1:0] last_ft;
  logic [2:0] last_ec;

  trace_line_checker_if in_if ();

  trace_line_checker dut (
    .clk         (clk),
    .reset       (reset),
    .in_if       (in_if),
    .format_type (format_type),
    .error_code  (error_code),
    .time_out    (time_out),
    .pc_out      (pc_out),
    .target_out  (target_out),
    .data_out    (data_out),
    .good_cnt    (good_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle the pulse is high, so a stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    if (format_type != 2'b00) begin
      pulses  = pulses + 1;
      last_ft = format_type;
      last_ec = error_code;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drives one character per cycle; gap idle cycles (with a decoy '#') after each.
  task automatic send(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      in_if.char       = s[i];
      in_if.char_valid = 1'b1;
      @(posedge clk); #1;
      if (gap > 0) begin
        in_if.char_valid = 1'b0;
        in_if.char       = "#";
        repeat (gap) begin @(posedge clk); #1; end
      end
    end
    in_if.char_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (2) begin @(posedge clk); #1; end
  endtask

  int p0;

  initial begin
    total = 0; bad = 0; pulses = 0; last_ft = 2'b00; last_ec = 3'd0;
    in_if.char = 8'h00; in_if.char_valid = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk); #1;
    reset = 1'b0;

    check("rst_ft",   64'(format_type), 64'd0);
    check("rst_ec",   64'(error_code),  64'd0);
    check("rst_time", 64'(time_out),    64'd0);
    check("rst_pc",   64'(pc_out),      64'd0);
    check("rst_tgt",  64'(target_out),  64'd0);
    check("rst_data", 64'(data_out),    64'd0);
    check("rst_good", 64'(good_cnt),    64'd0);

    // Register line, continuous valid; pulse is visible right after the '#' edge.
    p0 = pulses;
    send("^10@00003000: $5 <= 0000abcd#", 0);
    check("l1_ft",   64'(format_type), 64'd1);
    check("l1_ec",   64'(error_code),  64'd0);
    check("l1_time", 64'(time_out),    64'd10);
    check("l1_pc",   64'(pc_out),      64'h3000);
    check("l1_tgt",  64'(target_out),  64'd5);
    check("l1_data", 64'(data_out),    64'habcd);
    check("l1_good", 64'(good_cnt),    64'd1);
    @(posedge clk); #1;
    check("l1_drop", 64'(format_type), 64'd0);
    check("l1_ecz",  64'(error_code),  64'd0);

    // Memory line with idle cycles between characters.
    p0 = pulses;
    send("^7@00003004: *00000010<=ffffffff#", 1);
    settle();
    check("l2_pulses", 64'(pulses - p0), 64'd1);
    check("l2_ft",   64'(last_ft),    64'd2);
    check("l2_ec",   64'(last_ec),    64'd0);
    check("l2_time", 64'(time_out),   64'd7);
    check("l2_tgt",  64'(target_out), 64'h10);
    check("l2_data", 64'(data_out),   64'hffffffff);
    check("l2_good", 64'(good_cnt),   64'd2);

    // Syntax errors: no pulse, outputs untouched.
    p0 = pulses;
    send("^12345@00003000: $5 <= 00000001#", 0);
    send("^1@0000300A: $5 <= 00000001#", 0);
    send("^1@00003000: $<= 00000001#", 0);
    send("^1@00003000: $5 <= 1234 5678#", 0);
    settle();
    check("syn_pulses", 64'(pulses - p0), 64'd0);
    check("syn_good",   64'(good_cnt),    64'd2);
    check("syn_time",   64'(time_out),    64'd7);
    check("syn_pc",     64'(pc_out),      64'h3004);
    check("syn_data",   64'(data_out),    64'hffffffff);

    // Resync mid-PC.
    p0 = pulses;
    send("^1@0000^2@00003000:$1<=00000001#", 0);
    settle();
    check("rs_pulses", 64'(pulses - p0), 64'd1);
    check("rs_ft",     64'(last_ft),     64'd1);
    check("rs_time",   64'(time_out),    64'd2);
    check("rs_tgt",    64'(target_out),  64'd1);
    check("rs_good",   64'(good_cnt),    64'd3);

    // Semantic errors.
    send("^3@00002ffc: $1 <= 00000000#", 0); settle();
    check("se1_ec", 64'(last_ec), 64'd1);
    check("se1_ft", 64'(last_ft), 64'd1);
    send("^3@00003002: $1 <= 00000000#", 0); settle();
    check("se2_ec", 64'(last_ec), 64'd2);
    send("^3@00003000: $32 <= 00000000#", 0); settle();
    check("se3_ec",  64'(last_ec),    64'd3);
    check("se3_tgt", 64'(target_out), 64'd32);
    send("^3@00003000: *00000011 <= 00000000#", 0); settle();
    check("se4_ec", 64'(last_ec), 64'd4);
    check("se4_ft", 64'(last_ft), 64'd2);
    send("^3@00002ffe: $40 <= 00000000#", 0); settle();
    check("se5_ec", 64'(last_ec), 64'd1);
    send("^3@00007000: $1 <= 00000000#", 0); settle();
    check("se6_ec", 64'(last_ec), 64'd1);
    check("se_good", 64'(good_cnt), 64'd3);

    // Boundary: highest legal PC, max time digits, reg REG_COUNT-1.
    send("^9999@00006ffc:*00000000<=12345678#", 0); settle();
    check("pmax_ec",   64'(last_ec),  64'd0);
    check("pmax_time", 64'(time_out), 64'd9999);
    send("^0@00003000:$31<=00000000#", 0); settle();
    check("r31_ec",  64'(last_ec),  64'd0);
    check("r31_good", 64'(good_cnt), 64'd5);

    // Back-to-back lines, '^' lands in the pulse cycle.
    p0 = pulses;
    send("^1@00003000:$2<=00000002#^2@00003008:$3<=00000003#", 0);
    settle();
    check("b2b_pulses", 64'(pulses - p0), 64'd2);
    check("b2b_time",   64'(time_out),    64'd2);
    check("b2b_pc",     64'(pc_out),      64'h3008);
    check("b2b_good",   64'(good_cnt),    64'd7);

    // Reset mid-PC field, then stray tail and a full line.
    p0 = pulses;
    send("^5@0000", 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mr_good",  64'(good_cnt), 64'd0);
    check("mr_pc",    64'(pc_out),   64'd0);
    send("3000: $1 <= 00000001#", 0);
    settle();
    check("mr_nopulse", 64'(pulses - p0), 64'd0);
    send("^6@00003010: $4 <= 00000004#", 0);
    settle();
    check("mr_pulses", 64'(pulses - p0), 64'd1);
    check("mr_good1",  64'(good_cnt),    64'd1);
    check("mr_time",   64'(time_out),    64'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
